// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between the entry and exit lanes of a car park:
// round-robin arbitration, open/pass/close sequencing and free-slot tracking.
module parking_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_sensor,
  output logic             gate_open,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic [CNT_W-1:0] free_count,
  output logic             full,
  output logic             empty,
  output logic             timeout_pulse
);

  localparam int TMR_MAX = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN_ENTRY,
    S_OPEN_EXIT,
    S_PASSING,
    S_CLOSE
  } state_e;

  typedef enum logic {
    LANE_ENTRY,
    LANE_EXIT
  } lane_e;

  state_e           r_state, w_state_nxt;
  // The most recently granted lane also owns the gate for the whole episode.
  lane_e            r_last_served, w_last_served_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_free_count, w_free_nxt;

  logic r_gate_open, r_entry_grant, r_exit_grant;
  logic r_full, r_empty, r_timeout_pulse;

  logic w_entry_ok, w_exit_ok;
  logic w_timeout_nxt;
  logic w_entry_grant_nxt, w_exit_grant_nxt;

  assign w_entry_ok = entry_req & ~r_full;
  assign w_exit_ok  = exit_req  & ~r_empty;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    w_state_nxt       = r_state;
    w_last_served_nxt = r_last_served;
    w_timer_nxt       = r_timer + 1'b1;
    w_free_nxt        = r_free_count;
    w_timeout_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_entry_ok && (!w_exit_ok || r_last_served == LANE_EXIT)) begin
          w_state_nxt       = S_OPEN_ENTRY;
          w_last_served_nxt = LANE_ENTRY;
        end else if (w_exit_ok) begin
          w_state_nxt       = S_OPEN_EXIT;
          w_last_served_nxt = LANE_EXIT;
        end
      end

      S_OPEN_ENTRY, S_OPEN_EXIT: begin
        if (pass_sensor) begin
          w_state_nxt = S_PASSING;
          w_timer_nxt = '0;
        end else if (r_timer == OPEN_LAST) begin
          w_state_nxt   = S_CLOSE;
          w_timer_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end
      end

      S_PASSING: begin
        w_timer_nxt = '0;
        if (!pass_sensor) begin
          w_state_nxt = S_CLOSE;
          // Saturate even though eligibility already keeps the count in range.
          if (r_last_served == LANE_ENTRY) begin
            if (r_free_count != '0) w_free_nxt = r_free_count - 1'b1;
          end else begin
            if (r_free_count != CAP_CNT) w_free_nxt = r_free_count + 1'b1;
          end
        end
      end

      S_CLOSE: begin
        if (r_timer == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops directly.
  assign w_entry_grant_nxt = (w_state_nxt == S_OPEN_ENTRY) ||
                             (w_state_nxt == S_PASSING && w_last_served_nxt == LANE_ENTRY);
  assign w_exit_grant_nxt  = (w_state_nxt == S_OPEN_EXIT) ||
                             (w_state_nxt == S_PASSING && w_last_served_nxt == LANE_EXIT);

  always_ff @(posedge clock_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_in) begin
      r_state         <= S_IDLE;
      r_last_served   <= LANE_EXIT;
      r_timer         <= '0;
      r_free_count    <= CAP_CNT;
      r_gate_open     <= 1'b0;
      r_entry_grant   <= 1'b0;
      r_exit_grant    <= 1'b0;
      r_full          <= 1'b0;
      r_empty         <= 1'b1;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_last_served   <= w_last_served_nxt;
      r_timer         <= w_timer_nxt;
      r_free_count    <= w_free_nxt;
      r_gate_open     <= w_entry_grant_nxt | w_exit_grant_nxt;
      r_entry_grant   <= w_entry_grant_nxt;
      r_exit_grant    <= w_exit_grant_nxt;
      r_full          <= (w_free_nxt == '0);
      r_empty         <= (w_free_nxt == CAP_CNT);
      r_timeout_pulse <= w_timeout_nxt;
    end
  end

  assign gate_open     = r_gate_open;
  assign entry_grant   = r_entry_grant;
  assign exit_grant    = r_exit_grant;
  assign free_count    = r_free_count;
  assign full          = r_full;
  assign empty         = r_empty;
  assign timeout_pulse = r_timeout_pulse;

  a_grant_excl: assert property (@(posedge clock_in) disable iff (rst_in)
    !(r_entry_grant && r_exit_grant));
  a_gate_is_or: assert property (@(posedge clock_in) disable iff (rst_in)
    r_gate_open == (r_entry_grant | r_exit_grant));
  a_count_range: assert property (@(posedge clock_in) disable iff (rst_in)
    r_free_count <= CAP_CNT);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized bench for parking_gate_arbiter: a transaction-level model predicts
// each gate episode into a queue, and a monitor compares what the gate does.
module tb_parking_gate_arbiter;

  localparam int CAP   = 8;
  localparam int CNT_W = 4;
  localparam int OPEN  = 16;
  localparam int HOLD  = 4;

  logic             clock_in;
  logic             rst_in;
  logic             entry_req;
  logic             exit_req;
  logic             pass_sensor;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic [CNT_W-1:0] free_count;
  logic             full;
  logic             empty;
  logic             timeout_pulse;

  parking_gate_arbiter #(
    .CAPACITY   (CAP),
    .CNT_W      (CNT_W),
    .OPEN_CYCLES(OPEN),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock_in     (clock_in),
    .rst_in       (rst_in),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .pass_sensor  (pass_sensor),
    .gate_open    (gate_open),
    .entry_grant  (entry_grant),
    .exit_grant   (exit_grant),
    .free_count   (free_count),
    .full         (full),
    .empty        (empty),
    .timeout_pulse(timeout_pulse)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One predicted gate episode: from the grant rising to the gate dropping.
  typedef struct {
    bit lane_exit;
    int rise_cyc;
    int dur;
    bit tmo;
    int free_before;
    int free_after;
  } exp_t;

  exp_t q[$];

  // Reference model state: occupancy, round-robin memory, first edge the gate is idle.
  int m_free;
  bit m_last_exit;
  int m_free_at;
  bit mon_en = 1'b0;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic do_reset(input int n);
    rst_in      = 1'b1;
    entry_req   = 1'b0;
    exit_req    = 1'b0;
    pass_sensor = 1'b0;
    wait_neg(n);
    rst_in      = 1'b0;
    m_free      = CAP;
    m_last_exit = 1'b1;
    m_free_at   = cyc + 1;
  endtask

  // Raise the requested lanes, then either a pass (sensor low d cycles, high h
  // cycles), a timeout, or a reset abort after abort_k cycles under the beam.
  task automatic episode(input bit req_en, input bit req_ex, input bit pass,
                         input int d, input int h, input bit glitch, input int abort_k);
    int   s;
    int   c;
    bit   e_ok;
    bit   x_ok;
    exp_t r;
    s    = (cyc + 1 > m_free_at) ? cyc + 1 : m_free_at;
    e_ok = req_en && (m_free > 0);
    x_ok = req_ex && (m_free < CAP);
    entry_req = req_en;
    exit_req  = req_ex;

    if (!e_ok && !x_ok) begin
      while (cyc < s) @(negedge clock_in);
      for (int k = 0; k < 3; k++) begin
        check("no_grant", gate_open, 0);
        if (k < 2) @(negedge clock_in);
      end
      entry_req = 1'b0;
      exit_req  = 1'b0;
      return;
    end

    r.lane_exit   = (e_ok && x_ok) ? !m_last_exit : x_ok;
    r.rise_cyc    = s;
    r.free_before = m_free;
    if (pass && abort_k > 0) begin
      r.dur = d + abort_k + 1;  r.tmo = 1'b0;  r.free_after = CAP;
    end else if (pass) begin
      r.dur = d + h + 1;        r.tmo = 1'b0;
      r.free_after = m_free + (r.lane_exit ? 1 : -1);
    end else begin
      r.dur = OPEN;             r.tmo = 1'b1;  r.free_after = m_free;
    end
    q.push_back(r);
    m_last_exit = r.lane_exit;

    while (cyc < s) @(negedge clock_in);
    entry_req = 1'b0;
    exit_req  = 1'b0;

    if (pass) begin
      wait_neg(d);
      pass_sensor = 1'b1;
      if (abort_k > 0) begin
        wait_neg(abort_k);
        do_reset(1);
        return;
      end
      wait_neg(h);
      pass_sensor = 1'b0;
      c = s + d + h + 1;
    end else begin
      c = s + OPEN;
    end
    m_free    = r.free_after;
    m_free_at = c + HOLD + 1;
    while (cyc < c) @(negedge clock_in);
    if (glitch) begin
      pass_sensor = 1'b1;
      wait_neg(2);
      pass_sensor = 1'b0;
    end
  endtask

  // Monitor: samples on the falling edge and scores each episode it observes.
  initial begin
    exp_t cur;
    bit   in_ep;
    int   dur;
    in_ep = 1'b0;
    dur   = 0;
    forever begin
      @(negedge clock_in);
      if (mon_en) begin
        check("grant_excl", entry_grant & exit_grant, 0);
        check("gate_is_or", gate_open, entry_grant | exit_grant);
        if (!in_ep && gate_open === 1'b1) begin
          check("grant_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            cur   = q.pop_front();
            in_ep = 1'b1;
            dur   = 1;
            check("grant_latency", cyc, cur.rise_cyc);
            check("grant_lane_exit", exit_grant, cur.lane_exit);
            check("grant_lane_entry", entry_grant, !cur.lane_exit);
            check("free_at_open", free_count, cur.free_before);
          end
        end else if (in_ep && gate_open === 1'b1) begin
          dur++;
          check("lane_held", exit_grant, cur.lane_exit);
          check("free_while_open", free_count, cur.free_before);
          check("stray_timeout", timeout_pulse, 0);
        end else if (in_ep) begin
          in_ep = 1'b0;
          check("open_cycles", dur, cur.dur);
          check("timeout_pulse", timeout_pulse, cur.tmo);
          check("free_after", free_count, cur.free_after);
          check("full_after", full, cur.free_after == 0);
          check("empty_after", empty, cur.free_after == CAP);
        end else begin
          check("idle_timeout", timeout_pulse, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    entry_req   = 1'b0;
    exit_req    = 1'b0;
    pass_sensor = 1'b0;

    // Reset held for two edges.
    do_reset(2);
    check("rst_free", free_count, CAP);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_gate", gate_open, 0);
    check("rst_entry_grant", entry_grant, 0);
    check("rst_exit_grant", exit_grant, 0);
    check("rst_timeout", timeout_pulse, 0);
    mon_en = 1'b1;

    // Single entry with a 3-cycle pass, then a tie immediately after close.
    episode(1, 0, 1, 0, 3, 0, 0);
    episode(1, 1, 1, 1, 2, 0, 0);
    episode(1, 1, 1, 2, 2, 1, 0);

    // Empty/full boundaries.
    episode(0, 1, 1, 0, 1, 0, 0);
    episode(0, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < CAP; i++)
      episode(1, 0, 1, $urandom_range(0, OPEN - 1), $urandom_range(1, 4), 0, 0);
    check("lot_full_flag", full, 1);
    check("lot_full_count", free_count, 0);
    episode(1, 0, 1, 0, 1, 0, 0);
    episode(0, 1, 1, OPEN - 1, 1, 0, 0);

    // Unused open gate expires.
    episode(1, 0, 0, 0, 0, 1, 0);

    // Reset while a car is under the beam with five slots free.
    do_reset(1);
    for (int i = 0; i < 3; i++) episode(1, 0, 1, 1, 1, 0, 0);
    episode(1, 0, 1, 2, 0, 0, 3);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      wait_neg($urandom_range(0, 5));
      episode($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
              $urandom_range(0, OPEN - 1), $urandom_range(1, 5), $urandom_range(0, 1), 0);
    end

    wait_neg(HOLD + 4);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
